// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and defaults for the shift-left / shift-restore pair
package shift_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int SHIFT_AMT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE,
    UNSHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_restore.sv
// rtl/shift_restore.sv - undoes a SHIFT_AMT left shift, one bit per clock
// Optional low-bit error flag under SHIFT_RESTORE_ERR_CHECK_EN.
module shift_restore
  import shift_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SHIFT_AMT = SHIFT_AMT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    shifted_in,
  input  logic [SHIFT_AMT-1:0] carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 err_out,
  output logic                 busy
);

  localparam int CNT_W = $clog2(SHIFT_AMT + 1);

  generate
    if (SHIFT_AMT < 1 || SHIFT_AMT > DATA_W - 1) begin : g_bad_shift_amt
      $error("shift_restore: SHIFT_AMT must be in 1..DATA_W-1");
    end
  endgenerate

  state_t               r_state;
  state_t               w_next_state;
  logic [DATA_W-1:0]    r_work;
  logic [DATA_W-1:0]    r_data_out;
  logic [DATA_W-1:0]    w_step;
  logic [SHIFT_AMT-1:0] r_carry;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid;
  logic                 w_last_step;
  logic                 w_unused_work_lsb;

  // One restore step: the next lost bit re-enters at the MSB.
  function automatic logic [DATA_W-1:0] unshift_step(input logic [DATA_W-1:0] work,
                                                      input logic              carry_lsb);
    return {carry_lsb, work[DATA_W-1:1]};
  endfunction

  assign w_step            = unshift_step(r_work, r_carry[0]);
  assign w_last_step       = (r_cnt == CNT_W'(SHIFT_AMT - 1));
  assign w_unused_work_lsb = r_work[0];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_next_state = UNSHIFT;
      UNSHIFT: if (w_last_step) w_next_state = DONE;
      DONE:    if (out_ready)   w_next_state = IDLE;
      default:                  w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= shifted_in;
            r_carry <= carry_in;
            r_cnt   <= '0;
          end
        end
        UNSHIFT: begin
          r_work  <= w_step;
          r_carry <= r_carry >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last_step) begin
            r_data_out  <= w_step;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

`ifdef SHIFT_RESTORE_ERR_CHECK_EN
  logic r_err;
  logic r_err_out;

  // A genuine left shift leaves the low SHIFT_AMT bits zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) r_err <= |shifted_in[SHIFT_AMT-1:0];
      if (r_state == UNSHIFT && w_last_step) r_err_out <= r_err;
      else if (r_state == DONE && out_ready) r_err_out <= 1'b0;
    end
  end

  assign err_out = r_err_out;
`else
  assign err_out = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_shift_restore.sv
// tb/tb_shift_restore.sv - self-checking bench for shift_restore (SHIFT_AMT 1 and 3)
module tb_shift_restore;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef SHIFT_RESTORE_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err_out, a_busy;
  logic [7:0] a_shifted_in, a_data_out;
  logic [0:0] a_carry_in;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_out, b_busy;
  logic [7:0] b_shifted_in, b_data_out;
  logic [2:0] b_carry_in;

  shift_restore #(.DATA_W(8), .SHIFT_AMT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .shifted_in(a_shifted_in), .carry_in(a_carry_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .data_out(a_data_out), .err_out(a_err_out), .busy(a_busy)
  );

  shift_restore #(.DATA_W(8), .SHIFT_AMT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .shifted_in(b_shifted_in), .carry_in(b_carry_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_data_out), .err_out(b_err_out), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic a_accept(input logic [7:0] d, input logic c, input logic [7:0] exp);
    a_shifted_in = d;
    a_carry_in   = c;
    a_in_valid   = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    a_in_valid   = 1'b0;
    a_shifted_in = 8'hFF;
    a_carry_in   = ~c;
  endtask

  // Edges counted from the accept edge (inclusive) until out_valid is seen.
  task automatic a_wait_valid(output int edges);
    edges = 1;
    while (!a_out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic a_handshake();
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", a_data_out); end
    n_checks++; if (a_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err_out: got %b want 0", a_err_out); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b1 || b_busy !== 1'b0 || b_out_valid !== 1'b0 || b_data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_dut_b: in_ready=%b busy=%b out_valid=%b data=%h want 1 0 0 00",
                         b_in_ready, b_busy, b_out_valid, b_data_out);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] exp;
    a_accept(8'h56, 1'b1, 8'hAB);
    a_wait_valid(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 2", lat); end
    exp = pop_exp();
    n_checks++; if (a_data_out !== exp) begin n_fail++; $display("FAIL basic_data: got %h want %h", a_data_out, exp); end
    n_checks++; if (a_err_out !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", a_err_out); end
    a_handshake();
    n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_after_hs: out_valid=%b in_ready=%b want 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_shift3();
    int edges = 1;
    int bad = 0;
    b_shifted_in = 8'h28;
    b_carry_in   = 3'b110;
    b_in_valid   = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid   = 1'b0;
    b_shifted_in = 8'h00;
    b_carry_in   = 3'b000;
    while (!b_out_valid && edges < 50) begin
      if (b_busy !== 1'b1 || b_in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
      edges++;
    end
    n_checks++; if (edges !== 4) begin n_fail++; $display("FAIL shift3_latency: got %0d edges want 4", edges); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL shift3_busy: %0d bad cycles want 0", bad); end
    n_checks++; if (b_data_out !== 8'hC5) begin n_fail++; $display("FAIL shift3_data: got %h want c5", b_data_out); end
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
    n_checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL shift3_after_hs: out_valid=%b busy=%b want 0 0", b_out_valid, b_busy);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable = 0;
    logic [7:0] exp;
    a_accept(8'h56, 1'b1, 8'hAB);
    a_wait_valid(lat);
    exp = pop_exp();
    a_shifted_in = 8'h10;
    a_carry_in   = 1'b0;
    a_in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (a_data_out !== exp || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) unstable++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles want 0", unstable); end
    n_checks++; if (a_data_out !== exp) begin n_fail++; $display("FAIL bp_data: got %h want %h", a_data_out, exp); end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    n_checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_bypass: busy=%b in_ready=%b out_valid=%b want 0 1 0", a_busy, a_in_ready, a_out_valid);
    end
    @(posedge clk);
    #1;
    exp_q.push_back(8'h08);
    a_in_valid = 1'b0;
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: busy=%b want 1", a_busy); end
    a_wait_valid(lat);
    exp = pop_exp();
    n_checks++; if (a_data_out !== exp) begin n_fail++; $display("FAIL bp_second_data: got %h want %h", a_data_out, exp); end
    a_handshake();
    n_checks++; if (a_data_out !== 8'h08 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_data_kept: data=%h out_valid=%b want 08 0", a_data_out, a_out_valid);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [7:0] exp;
    a_accept(8'h10, 1'b1, 8'h88);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_data_out !== 8'h00 || a_err_out !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: busy=%b in_ready=%b out_valid=%b data=%h err=%b want 0 1 0 00 0",
                         a_busy, a_in_ready, a_out_valid, a_data_out, a_err_out);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_accept(8'h56, 1'b1, 8'hAB);
    a_wait_valid(lat);
    exp = pop_exp();
    n_checks++; if (a_data_out !== exp) begin n_fail++; $display("FAIL midop_after_data: got %h want %h", a_data_out, exp); end
    a_handshake();
  endtask

  task automatic test_err();
    int lat;
    logic [7:0] exp;
    a_accept(8'h57, 1'b0, 8'h2B);
    a_wait_valid(lat);
    exp = pop_exp();
    n_checks++; if (a_data_out !== exp) begin n_fail++; $display("FAIL err_data: got %h want %h", a_data_out, exp); end
    n_checks++; if (a_err_out !== ERR_EN) begin n_fail++; $display("FAIL err_flag: got %b want %b", a_err_out, ERR_EN); end
    a_handshake();
    n_checks++; if (a_err_out !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", a_err_out); end
  endtask

  task automatic test_round_trip();
    logic [7:0] src[256];
    logic [7:0] exp;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
    while (got < 256 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (idx < 256) begin
        a_in_valid   = ($urandom_range(0, 3) != 0);
        a_shifted_in = {src[idx][6:0], 1'b0};
        a_carry_in   = src[idx][7];
      end else begin
        a_in_valid = 1'b0;
      end
      a_out_ready = ($urandom_range(0, 2) != 0);
      if (a_in_valid && a_in_ready) begin
        exp_q.push_back(src[idx]);
        idx++;
      end
      if (a_out_valid && a_out_ready) begin
        exp = pop_exp();
        n_checks++; if (a_data_out !== exp || a_err_out !== 1'b0) begin
          n_fail++; $display("FAIL round_trip[%0d]: data=%h err=%b want %h 0", got, a_data_out, a_err_out, exp);
        end
        got++;
      end
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    n_checks++; if (got !== 256 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL round_trip_count: got %0d outputs, %0d pending, want 256 0", got, exp_q.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    a_in_valid   = 1'b0;
    a_out_ready  = 1'b0;
    a_shifted_in = 8'h00;
    a_carry_in   = 1'b0;
    b_in_valid   = 1'b0;
    b_out_ready  = 1'b0;
    b_shifted_in = 8'h00;
    b_carry_in   = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_shift3();
    test_backpressure();
    test_reset_midop();
    test_err();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
